// File: rtl/sprite_fetch_arb.sv
// Round-robin arbiter sharing one fixed-latency sprite ROM between burst requesters.
// Returning words are tagged with requester id and last flag, aligned to the ROM latency.
module sprite_fetch_arb #(
    parameter int NUM_REQ = 3,
    parameter int LEN_W   = 11,
    parameter int ROM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*3-1:0]     sprite_i,
    input  logic [NUM_REQ*10-1:0]    addr_i,
    input  logic [NUM_REQ*LEN_W-1:0] len_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic [2:0]               rom_sprite_o,
    output logic [9:0]               rom_addr_o,
    input  logic [15:0]              rom_data_i,
    output logic                     rd_valid_o,
    output logic [2:0]               rd_id_o,
    output logic                     rd_last_o,
    output logic [15:0]              rd_data_o,
    output logic                     busy_o
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         rr_ptr, gnt_id, cur_id;
    logic               gnt_found, grant;
    logic [2:0]         gnt_sprite;
    logic [9:0]         gnt_addr;
    logic [LEN_W-1:0]   gnt_len, remain;
    logic               push_valid, push_last;
    logic [NUM_REQ-1:0] zero_done;
    logic [ROM_LAT-1:0] tag_valid, tag_last;
    logic [2:0]         tag_id [ROM_LAT];

    // Two passes give "first set bit at or above rr_ptr, else first set bit from 0".
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_i[i] && 3'(i) >= rr_ptr) begin
                gnt_found = 1'b1;
                gnt_id    = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_i[i]) begin
                gnt_found = 1'b1;
                gnt_id    = 3'(i);
            end
        end
    end

    always_comb begin
        gnt_sprite = '0;
        gnt_addr   = '0;
        gnt_len    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == 3'(i)) begin
                gnt_sprite = sprite_i[3*i +: 3];
                gnt_addr   = addr_i[10*i +: 10];
                gnt_len    = len_i[LEN_W*i +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ack_o      = '0;
        grant      = 1'b0;
        push_valid = 1'b0;
        push_last  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    grant = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ack_o[i] = rst_n && (gnt_id == 3'(i));
                    end
                    if (gnt_len != '0) state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                push_valid = 1'b1;
                push_last  = (remain == LEN_W'(1));
                if (push_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            cur_id       <= '0;
            remain       <= '0;
            rom_addr_o   <= '0;
            rom_sprite_o <= '0;
            zero_done    <= '0;
        end else begin
            zero_done <= '0;
            if (grant) begin
                rr_ptr <= (gnt_id == 3'(NUM_REQ-1)) ? 3'd0 : gnt_id + 3'd1;
                if (gnt_len == '0) begin
                    zero_done <= ack_o;
                end else begin
                    cur_id       <= gnt_id;
                    remain       <= gnt_len;
                    rom_addr_o   <= gnt_addr;
                    rom_sprite_o <= gnt_sprite;
                end
            end else if (state == ISSUE && !push_last) begin
                // 10-bit add wraps 1023 -> 0 inside a burst.
                rom_addr_o <= rom_addr_o + 10'd1;
                remain     <= remain - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_last  <= '0;
            for (int i = 0; i < ROM_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_valid[0] <= push_valid;
            tag_last[0]  <= push_last;
            tag_id[0]    <= push_valid ? cur_id : 3'd0;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign rd_valid_o = tag_valid[ROM_LAT-1];
    assign rd_last_o  = tag_last[ROM_LAT-1];
    assign rd_id_o    = tag_id[ROM_LAT-1];
    assign rd_data_o  = rom_data_i;
    assign busy_o     = (state == ISSUE) || (|tag_valid);

    always_comb begin
        done_o = zero_done;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_valid_o && rd_last_o && rd_id_o == 3'(i)) done_o[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_fetch_arb.sv
// Directed bench for sprite_fetch_arb with a 2-cycle ROM model and assertion-based checks.
module tb_sprite_fetch_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [8:0]  sprite;
    logic [29:0] addr;
    logic [32:0] len;
    logic [2:0]  ack, done;
    logic [2:0]  rom_sprite;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] rom_d1 = '0;
    logic        rd_valid, rd_last, busy;
    logic [2:0]  rd_id;
    logic [15:0] rd_data;
    int          total = 0;
    int          bad = 0;

    int t2_ack[11] = '{1, 0, 2, 0, 4, 0, 1, 0, 0, 0, 0};
    int t2_vld[11] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int t2_id[11]  = '{0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0};
    int t2_dat[11] = '{0, 0, 0, 'h3500, 0, 'h7600, 0, 'h0000, 0, 'h3500, 0};

    int t5_ack[9]  = '{1, 0, 0, 2, 0, 0, 0, 0, 0};
    int t5_adr[9]  = '{0, 'h020, 'h021, 'h021, 'h040, 'h041, 'h041, 'h041, 'h041};
    int t5_vld[9]  = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
    int t5_id[9]   = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    int t5_lst[9]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    int t5_dat[9]  = '{0, 0, 0, 'h9420, 'h9421, 0, 'hD440, 'hD441, 0};

    always #5 clk = ~clk;

    sprite_fetch_arb dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .sprite_i(sprite), .addr_i(addr),
        .len_i(len), .ack_o(ack), .done_o(done), .rom_sprite_o(rom_sprite),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .rd_valid_o(rd_valid),
        .rd_id_o(rd_id), .rd_last_o(rd_last), .rd_data_o(rd_data), .busy_o(busy)
    );

    function automatic logic [15:0] rom_word(input logic [2:0] s, input logic [9:0] a);
        return (s == 3'd7) ? 16'h0000 : {s, 3'b101, a};
    endfunction

    // ROM model: word for the address seen in cycle t appears in cycle t+2.
    always @(posedge clk) begin
        rom_d1   <= rom_word(rom_sprite, rom_addr);
        rom_data <= rom_d1;
    end

    function automatic logic [2:0] oh(input int id);
        return 3'(1 << id);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] s, input logic [9:0] a, input int n);
        sprite[3*id +: 3] = s;
        addr[10*id +: 10] = a;
        len[11*id +: 11]  = 11'(n);
        req[id]           = 1'b1;
    endtask

    task automatic run_burst(input string name, input int id, input logic [2:0] s,
                             input logic [9:0] a, input int n);
        tick();
        set_req(id, s, a, n);
        #1;
        chk({name, " ack"}, 32'(ack), 32'(oh(id)));
        for (int j = 1; j <= n + 3; j++) begin
            tick();
            req[id] = 1'b0;
            #1;
            chk($sformatf("%s addr c%0d", name, j), 32'(rom_addr),
                32'(10'(a + ((j <= n) ? j - 1 : n - 1))));
            chk($sformatf("%s sprite c%0d", name, j), 32'(rom_sprite), 32'(s));
            chk($sformatf("%s valid c%0d", name, j), 32'(rd_valid), 32'(j >= 3 && j <= n + 2));
            if (j >= 3 && j <= n + 2) begin
                chk($sformatf("%s id c%0d", name, j), 32'(rd_id), 32'(id));
                chk($sformatf("%s last c%0d", name, j), 32'(rd_last), 32'(j == n + 2));
                chk($sformatf("%s data c%0d", name, j), 32'(rd_data), 32'(rom_word(s, 10'(a + j - 3))));
            end
            chk($sformatf("%s done c%0d", name, j), 32'(done), (j == n + 2) ? 32'(oh(id)) : 32'd0);
            chk($sformatf("%s busy c%0d", name, j), 32'(busy), 32'(j <= n + 2));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; sprite = '0; addr = '0; len = '0;
        tick(); tick();
        chk("rst ack", 32'(ack), 0);
        chk("rst done", 32'(done), 0);
        chk("rst valid", 32'(rd_valid), 0);
        chk("rst last", 32'(rd_last), 0);
        chk("rst id", 32'(rd_id), 0);
        chk("rst addr", 32'(rom_addr), 0);
        chk("rst sprite", 32'(rom_sprite), 0);
        chk("rst busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // T1: single burst from requester 0.
        run_burst("t1", 0, 3'd2, 10'h010, 4);

        // T3: address wrap inside a burst, requester 1.
        run_burst("t3", 1, 3'd5, 10'h3FE, 4);

        // T4: zero-length burst from requester 2.
        tick();
        set_req(2, 3'd1, 10'h123, 0);
        #1;
        chk("t4 ack", 32'(ack), 32'b100);
        chk("t4 busy0", 32'(busy), 0);
        tick();
        req[2] = 1'b0;
        #1;
        chk("t4 done", 32'(done), 32'b100);
        chk("t4 valid", 32'(rd_valid), 0);
        chk("t4 busy1", 32'(busy), 0);
        chk("t4 ack off", 32'(ack), 0);
        tick();
        #1;
        chk("t4 done off", 32'(done), 0);
        chk("t4 busy2", 32'(busy), 0);

        // T2: all requesters held, one-word bursts; pointer starts at 0.
        for (int c = 0; c <= 10; c++) begin
            tick();
            if (c == 0) begin
                set_req(0, 3'd1, 10'h100, 1);
                set_req(1, 3'd3, 10'h200, 1);
                set_req(2, 3'd7, 10'h300, 1);
            end
            if (c == 7) req = '0;
            #1;
            chk($sformatf("t2 ack c%0d", c), 32'(ack), 32'(t2_ack[c]));
            chk($sformatf("t2 valid c%0d", c), 32'(rd_valid), 32'(t2_vld[c]));
            chk($sformatf("t2 busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 9));
            if (t2_vld[c] != 0) begin
                chk($sformatf("t2 id c%0d", c), 32'(rd_id), 32'(t2_id[c]));
                chk($sformatf("t2 last c%0d", c), 32'(rd_last), 1);
                chk($sformatf("t2 data c%0d", c), 32'(rd_data), 32'(t2_dat[c]));
                chk($sformatf("t2 done c%0d", c), 32'(done), 32'(oh(t2_id[c])));
            end else begin
                chk($sformatf("t2 done c%0d", c), 32'(done), 0);
            end
        end

        // T5: two 2-word bursts back to back; req1 raised while burst 0 issues.
        for (int c = 0; c <= 8; c++) begin
            tick();
            if (c == 0) set_req(0, 3'd4, 10'h020, 2);
            if (c == 1) begin
                req[0] = 1'b0;
                set_req(1, 3'd6, 10'h040, 2);
            end
            if (c == 4) req[1] = 1'b0;
            #1;
            chk($sformatf("t5 ack c%0d", c), 32'(ack), 32'(t5_ack[c]));
            if (c >= 1) chk($sformatf("t5 addr c%0d", c), 32'(rom_addr), 32'(t5_adr[c]));
            chk($sformatf("t5 valid c%0d", c), 32'(rd_valid), 32'(t5_vld[c]));
            if (t5_vld[c] != 0) begin
                chk($sformatf("t5 id c%0d", c), 32'(rd_id), 32'(t5_id[c]));
                chk($sformatf("t5 last c%0d", c), 32'(rd_last), 32'(t5_lst[c]));
                chk($sformatf("t5 data c%0d", c), 32'(rd_data), 32'(t5_dat[c]));
            end
            chk($sformatf("t5 done c%0d", c), 32'(done),
                (t5_lst[c] != 0) ? 32'(oh(t5_id[c])) : 32'd0);
        end

        // T6: reset while the third word of an 8-word burst is delivered.
        for (int c = 0; c <= 5; c++) begin
            tick();
            if (c == 0) set_req(0, 3'd2, 10'h080, 8);
            if (c == 1) req[0] = 1'b0;
            #1;
            if (c == 0) chk("t6 ack", 32'(ack), 32'b001);
        end
        chk("t6 third valid", 32'(rd_valid), 1);
        chk("t6 third data", 32'(rd_data), 32'h5482);
        rst_n = 1'b0;
        #1;
        chk("t6 rst valid", 32'(rd_valid), 0);
        chk("t6 rst id", 32'(rd_id), 0);
        chk("t6 rst addr", 32'(rom_addr), 0);
        chk("t6 rst sprite", 32'(rom_sprite), 0);
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst done", 32'(done), 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            chk($sformatf("t6 hold done c%0d", c), 32'(done), 0);
            chk($sformatf("t6 hold valid c%0d", c), 32'(rd_valid), 0);
        end
        rst_n = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            tick();
            if (c == 0) begin
                set_req(0, 3'd0, 10'h005, 1);
                set_req(2, 3'd3, 10'h006, 1);
            end
            if (c == 1) req = '0;
            #1;
            if (c == 0) chk("t6 post ack", 32'(ack), 32'b001);
            if (c == 1) chk("t6 post addr", 32'(rom_addr), 32'h005);
            chk($sformatf("t6 post valid c%0d", c), 32'(rd_valid), 32'(c == 3));
            chk($sformatf("t6 post done c%0d", c), 32'(done), (c == 3) ? 32'b001 : 32'd0);
            if (c == 3) chk("t6 post data", 32'(rd_data), 32'h1405);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
